// File: rtl/flasher_pkg.sv
// Shared definitions for the bound-flasher controller.
// Used by both the next-state generator and the sequential datapath:
//   - main state encodings
//   - count command encodings
//   - default LED count and counter width
//   - a helper that folds the unused state encoding back to INIT_STATE
package flasher_pkg;

   localparam int LED_NUM_DEF = 16;
   localparam int CNT_W_DEF   = 5;

   typedef enum logic [2:0] {
      INIT_STATE       = 3'd0,
      ONLED0_15_STATE  = 3'd1,
      OFFLED15_5_STATE = 3'd2,
      ONLED5_10_STATE  = 3'd3,
      OFFLED10_0_STATE = 3'd4,
      ONLED0_5_STATE   = 3'd5,
      OFFLED5_0_STATE  = 3'd6
   } main_state_t;

   typedef enum logic [1:0] {
      COUNT_DIS     = 2'b00,
      COUNT_UP_EN   = 2'b01,
      COUNT_DOWN_EN = 2'b10
   } count_state_t;

   // 3'd7 is not a legal state; treat it as a request to restart from INIT.
   function automatic logic [2:0] sanitize_state(input logic [2:0] state_in);
      logic [2:0] result;
      result = state_in;
      if (state_in == 3'd7) begin
         result = INIT_STATE;
      end
      return result;
   endfunction

endpackage

// File: rtl/flasher_counter.sv
// Saturating load/up/down LED counter plus the registered thermometer bar.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load_value, load_en immediate load (clamped to LED_NUM), wins over counting
//   count_state         COUNT_DIS / COUNT_UP_EN / COUNT_DOWN_EN (2'b11 holds)
//   counter             registered count, 0..LED_NUM
//   led                 registered thermometer of counter (led[i] = i < counter)
module flasher_counter
   import flasher_pkg::*;
#(
   parameter int LED_NUM = LED_NUM_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [CNT_W-1:0]   load_value,
   input  logic               load_en,
   input  logic [1:0]         count_state,
   output logic [CNT_W-1:0]   counter,
   output logic [LED_NUM-1:0] led
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(LED_NUM);

   logic [CNT_W-1:0]   counter_next;
   logic [LED_NUM-1:0] led_next;

   always_comb begin
      counter_next = counter;
      if (load_en) begin
         counter_next = (load_value > MAX_CNT) ? MAX_CNT : load_value;
      end else begin
         case (count_state)
            COUNT_UP_EN: begin
               if (counter < MAX_CNT) begin
                  counter_next = counter + CNT_W'(1);
               end
            end
            COUNT_DOWN_EN: begin
               if (counter != '0) begin
                  counter_next = counter - CNT_W'(1);
               end
            end
            default: counter_next = counter;
         endcase
      end
   end

   // Decoding the bar from counter_next keeps led aligned with counter on
   // every cycle instead of trailing it by one.
   for (genvar gi = 0; gi < LED_NUM; gi++) begin : g_thermo
      assign led_next[gi] = (counter_next > CNT_W'(gi));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter <= '0;
         led     <= '0;
      end else begin
         counter <= counter_next;
         led     <= led_next;
      end
   end

endmodule

// File: rtl/flasher_datapath.sv
// Sequential half of the bound-flasher controller.
// Holds the main state register and the LED counter, applies the generator's
// next-state/load/count commands and returns counter and kickback feedback.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flick            user flick request (synchronous)
//   main_state_n     next main state from the generator
//   counter_load     load value, counter_load_en load strobe (priority)
//   count_state      count command
//   main_state       registered current state
//   counter          registered LED count
//   kickback_match   combinational kickback condition
//   led              registered thermometer bar
module flasher_datapath
   import flasher_pkg::*;
#(
   parameter int LED_NUM = LED_NUM_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flick,
   input  logic [2:0]         main_state_n,
   input  logic [CNT_W-1:0]   counter_load,
   input  logic               counter_load_en,
   input  logic [1:0]         count_state,
   output logic [2:0]         main_state,
   output logic [CNT_W-1:0]   counter,
   output logic               kickback_match,
   output logic [LED_NUM-1:0] led
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_state <= INIT_STATE;
      end else begin
         main_state <= sanitize_state(main_state_n);
      end
   end

   flasher_counter #(
      .LED_NUM (LED_NUM),
      .CNT_W   (CNT_W)
   ) u_counter (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_value  (counter_load),
      .load_en     (counter_load_en),
      .count_state (count_state),
      .counter     (counter),
      .led         (led)
   );

   // Kickback points: the 5-LED trough of OFFLED15_5 and the empty trough of
   // OFFLED10_0. OFFLED5_0 reaching 0 is deliberately not a kickback point.
   always_comb begin
      kickback_match = flick &
         (((main_state == OFFLED15_5_STATE) && (counter == CNT_W'(5))) ||
          ((main_state == OFFLED10_0_STATE) && (counter == CNT_W'(0))));
   end

endmodule
